// File: rtl/POLI_types_pkg.sv
// Shared types and constants for the polymorphic CRC peripheral.
// Holds the CRC-32 / CRC-32C polynomials (normal and reflected), the
// CRC engine state encoding and the orientation-word bit positions.
package POLI_types_pkg;

   localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32C_POLY      = 32'h1EDC_6F41;
   localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB8_8320;
   localparam logic [31:0] CRC32C_POLY_REFL = 32'h82F6_3B78;

   localparam int ORIENT_POLY_BIT = 0;
   localparam int ORIENT_LSB_BIT  = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } crc_state_t;

   // Pick the polynomial constant matching the selected CRC and bit order;
   // LSB-first folding uses the bit-reversed form of the polynomial.
   function automatic logic [31:0] sel_poly(input logic poly_c, input logic lsb_first);
      logic [31:0] p;
      if (lsb_first) begin
         p = poly_c ? CRC32C_POLY_REFL : CRC32_POLY_REFL;
      end else begin
         p = poly_c ? CRC32C_POLY : CRC32_POLY;
      end
      return p;
   endfunction

endpackage

// File: rtl/crc32_engine_step.sv
// Combinational single-bit CRC-32 fold. The polynomial is supplied by the
// caller already in the form matching the bit order (reflected for LSB-first).
module crc32_step (
   input  logic [31:0] i_crc,
   input  logic        i_d,
   input  logic [31:0] i_poly,
   input  logic        i_lsb_first,
   output logic [31:0] o_crc_next
);

   logic w_fb;

   // Fold one data bit: feedback comes from the outgoing end of the register.
   always_comb begin
      w_fb       = 1'b0;
      o_crc_next = i_crc;
      if (i_lsb_first) begin
         w_fb       = i_crc[0] ^ i_d;
         o_crc_next = {1'b0, i_crc[31:1]} ^ (w_fb ? i_poly : 32'h0000_0000);
      end else begin
         w_fb       = i_crc[31] ^ i_d;
         o_crc_next = {i_crc[30:0], 1'b0} ^ (w_fb ? i_poly : 32'h0000_0000);
      end
   end

endmodule

// File: rtl/crc32_engine.sv
// Word-serial CRC-32 engine: folds a 32-bit word into a running CRC at
// BITS_PER_CYCLE bits per clock. Orientation selects CRC-32 / CRC-32C and
// MSB-first / LSB-first consumption. The CRC chains across words until
// crc_reset. Build option CRC32_FINAL_XOR_EN inverts the reported value
// (the internal register is unaffected).
module crc32_engine
   import POLI_types_pkg::*;
#(
   parameter int          BITS_PER_CYCLE = 1,
   parameter logic [31:0] INIT_VALUE     = 32'hFFFF_FFFF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] crc_data_in,
   input  logic        crc_start,
   input  logic        crc_reset,
   input  logic [31:0] crc_orient,
   output logic [31:0] crc_data_out,
   output logic        crc_ready
);

   localparam int N  = 32 / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   crc_state_t    r_state;
   crc_state_t    w_next_state;
   logic [31:0]   r_crc;
   logic [31:0]   r_data;
   logic [CW-1:0] r_cnt;
   logic          r_lsb;
   logic          r_poly_c;
   logic [31:0]   w_poly;
   logic [31:0]   w_data_shift;
   logic [31:0]   w_chain [0:BITS_PER_CYCLE];
   logic          w_accept;
   logic          w_unused_orient;

   // Reserved orientation bits have no function.
   assign w_unused_orient = ^crc_orient[31:2];

   assign w_accept = (r_state == IDLE) && crc_start && !crc_reset;
   assign w_poly   = sel_poly(r_poly_c, r_lsb);
   assign w_chain[0] = r_crc;

   genvar k;
   generate
      for (k = 0; k < BITS_PER_CYCLE; k++) begin : g_fold
         crc32_step u_step (
            .i_crc       (w_chain[k]),
            .i_d         (r_lsb ? r_data[k] : r_data[31-k]),
            .i_poly      (w_poly),
            .i_lsb_first (r_lsb),
            .o_crc_next  (w_chain[k+1])
         );
      end
   endgenerate

   // Drop the bits consumed this cycle so the next ones sit at the fold end.
   always_comb begin
      w_data_shift = r_data;
      if (r_lsb) begin
         w_data_shift = r_data >> BITS_PER_CYCLE;
      end else begin
         w_data_shift = r_data << BITS_PER_CYCLE;
      end
   end

   // Next-state logic; crc_reset forces IDLE and beats a simultaneous start.
   always_comb begin
      w_next_state = r_state;
      if (crc_reset) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_next_state = crc_start ? RUN : IDLE;
            RUN:     w_next_state = (r_cnt == CNT_ZERO) ? IDLE : RUN;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath: latch word/orientation on accept, fold while running.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_crc    <= INIT_VALUE;
         r_data   <= 32'h0000_0000;
         r_cnt    <= CNT_ZERO;
         r_lsb    <= 1'b0;
         r_poly_c <= 1'b0;
      end else if (crc_reset) begin
         r_crc    <= INIT_VALUE;
         r_cnt    <= CNT_ZERO;
      end else if (w_accept) begin
         r_data   <= crc_data_in;
         r_lsb    <= crc_orient[ORIENT_LSB_BIT];
         r_poly_c <= crc_orient[ORIENT_POLY_BIT];
         r_cnt    <= CNT_LOAD;
      end else if (r_state == RUN) begin
         r_crc    <= w_chain[BITS_PER_CYCLE];
         r_data   <= w_data_shift;
         r_cnt    <= (r_cnt == CNT_ZERO) ? CNT_ZERO : (r_cnt - CW'(1));
      end else begin
         r_crc    <= r_crc;
      end
   end

   assign crc_ready = (r_state == IDLE);

`ifdef CRC32_FINAL_XOR_EN
   assign crc_data_out = r_crc ^ 32'hFFFF_FFFF;
`else
   assign crc_data_out = r_crc;
`endif

endmodule

// File: tb/tb_crc32_engine.sv
// Directed bench for crc32_engine: reset state, CRC-32/CRC-32C in both bit
// orders, busy-start rejection, crc_reset priority/abort, async reset and a
// chaining/latency sweep over BITS_PER_CYCLE = 1, 8, 32.
module tb_crc32_engine;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] crc_data_in = 32'h0000_0000;
   logic        crc_reset = 1'b0;
   logic [31:0] crc_orient = 32'h0000_0000;
   logic [2:0]  start_v = 3'b000;
   logic [2:0]  ready_v;
   logic [31:0] out0, out1, out2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   crc32_engine #(.BITS_PER_CYCLE(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .crc_data_in(crc_data_in), .crc_start(start_v[0]),
      .crc_reset(crc_reset), .crc_orient(crc_orient),
      .crc_data_out(out0), .crc_ready(ready_v[0]));

   crc32_engine #(.BITS_PER_CYCLE(8)) u_dut8 (
      .CLK(CLK), .RST(RST), .crc_data_in(crc_data_in), .crc_start(start_v[1]),
      .crc_reset(crc_reset), .crc_orient(crc_orient),
      .crc_data_out(out1), .crc_ready(ready_v[1]));

   crc32_engine #(.BITS_PER_CYCLE(32)) u_dut32 (
      .CLK(CLK), .RST(RST), .crc_data_in(crc_data_in), .crc_start(start_v[2]),
      .crc_reset(crc_reset), .crc_orient(crc_orient),
      .crc_data_out(out2), .crc_ready(ready_v[2]));

   // Reference bit-serial CRC over one 32-bit word.
   function automatic logic [31:0] model(input logic [31:0] crc_in, input logic [31:0] d,
                                         input logic poly_c, input logic lsb);
      logic [31:0] c;
      logic [31:0] p;
      logic        fb;
      c = crc_in;
      if (lsb) p = poly_c ? 32'h82F6_3B78 : 32'hEDB8_8320;
      else     p = poly_c ? 32'h1EDC_6F41 : 32'h04C1_1DB7;
      for (int i = 0; i < 32; i++) begin
         if (lsb) begin
            fb = c[0] ^ d[i];
            c  = (c >> 1) ^ (fb ? p : 32'h0);
         end else begin
            fb = c[31] ^ d[31-i];
            c  = (c << 1) ^ (fb ? p : 32'h0);
         end
      end
      return c;
   endfunction

   function automatic logic [31:0] exp_out(input logic [31:0] raw);
`ifdef CRC32_FINAL_XOR_EN
      return raw ^ 32'hFFFF_FFFF;
`else
      return raw;
`endif
   endfunction

   function automatic logic [31:0] get_out(input int idx);
      if (idx == 0) return out0;
      else if (idx == 1) return out1;
      else return out2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset();
      crc_reset = 1'b1;
      tick();
      crc_reset = 1'b0;
   endtask

   // Start a word on instance idx and count the cycles ready stays low.
   task automatic run_word(input int idx, input logic [31:0] data, input int exp_low,
                           input string tag);
      int n;
      crc_data_in  = data;
      start_v[idx] = 1'b1;
      tick();
      start_v = 3'b000;
      n = 0;
      while (ready_v[idx] == 1'b0 && n < 200) begin
         n++;
         tick();
      end
      check(tag, 32'(n), 32'(exp_low));
   endtask

   initial begin
      int n;
      logic [31:0] e;

      // Reset state
      tick();
      tick();
      check("rst_ready", {31'd0, ready_v[0]}, 32'd1);
      check("rst_out",   out0, exp_out(32'hFFFF_FFFF));
      RST = 1'b0;
      tick();
      check("post_rst_out", out0, exp_out(32'hFFFF_FFFF));

      // LSB-first CRC-32 over a zero word
      crc_orient = 32'h0000_0002;
      pulse_reset();
      run_word(0, 32'h0000_0000, 32, "crc32_lsb_low");
      check("crc32_lsb_zero", out0, exp_out(32'hDEBB_20E3));

      // LSB-first CRC-32C over a zero word
      crc_orient = 32'h0000_0003;
      pulse_reset();
      run_word(0, 32'h0000_0000, 32, "crc32c_lsb_low");
      check("crc32c_lsb_zero", out0, exp_out(32'hB798_B438));

      // Busy start ignored, orient/data changes during RUN have no effect
      crc_orient = 32'h0000_0000;
      pulse_reset();
      crc_data_in = 32'hA5A5_A5A5;
      start_v[0]  = 1'b1;
      tick();
      start_v[0] = 1'b0;
      check("busy_ready_fell", {31'd0, ready_v[0]}, 32'd0);
      n = 0;
      while (ready_v[0] == 1'b0 && n < 200) begin
         n++;
         if (n == 5) begin
            start_v[0]  = 1'b1;
            crc_data_in = 32'hFFFF_FFFF;
            crc_orient  = 32'h0000_0003;
         end else begin
            start_v[0]  = 1'b0;
            crc_orient  = 32'hFFFF_FFFE;
         end
         tick();
      end
      start_v[0] = 1'b0;
      crc_orient = 32'h0000_0000;
      check("busy_low", 32'(n), 32'd32);
      check("busy_result", out0, exp_out(model(32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b0, 1'b0)));
      tick();
      check("busy_no_queue", {31'd0, ready_v[0]}, 32'd1);

      // crc_reset with simultaneous start: stay idle, register cleared
      crc_reset   = 1'b1;
      start_v[0]  = 1'b1;
      crc_data_in = 32'h1234_5678;
      tick();
      crc_reset  = 1'b0;
      start_v[0] = 1'b0;
      check("rs_ready", {31'd0, ready_v[0]}, 32'd1);
      check("rs_out", out0, exp_out(32'hFFFF_FFFF));
      tick();
      tick();
      check("rs_ready_hold", {31'd0, ready_v[0]}, 32'd1);
      check("rs_out_hold", out0, exp_out(32'hFFFF_FFFF));

      // crc_reset aborts an in-flight word
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      tick();
      tick();
      pulse_reset();
      check("abort_ready", {31'd0, ready_v[0]}, 32'd1);
      check("abort_out", out0, exp_out(32'hFFFF_FFFF));

      // Asynchronous RST in the middle of RUN
      crc_data_in = 32'hDEAD_BEEF;
      start_v[0]  = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      tick();
      #2;
      RST = 1'b1;
      #1;
      check("async_rst_ready", {31'd0, ready_v[0]}, 32'd1);
      check("async_rst_out", out0, exp_out(32'hFFFF_FFFF));
      #2;
      RST = 1'b0;
      tick();
      check("async_rst_hold", out0, exp_out(32'hFFFF_FFFF));

      // MSB-first CRC-32C with reserved orient bits set
      crc_orient = 32'hFFFF_FFFD;
      pulse_reset();
      run_word(0, 32'h1234_5678, 32, "msb_c_low");
      check("msb_c_resv", out0, exp_out(model(32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0)));

      // Chaining and latency sweep across BITS_PER_CYCLE = 1, 8, 32
      crc_orient = 32'h0000_0002;
      e = model(model(32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b1), 32'h9ABC_DEF0, 1'b0, 1'b1);
      pulse_reset();
      run_word(0, 32'h1234_5678, 32, "sweep1_w0_low");
      run_word(0, 32'h9ABC_DEF0, 32, "sweep1_w1_low");
      check("sweep1_crc", out0, exp_out(e));
      pulse_reset();
      run_word(1, 32'h1234_5678, 4, "sweep8_w0_low");
      run_word(1, 32'h9ABC_DEF0, 4, "sweep8_w1_low");
      check("sweep8_crc", get_out(1), exp_out(e));
      pulse_reset();
      run_word(2, 32'h1234_5678, 1, "sweep32_w0_low");
      run_word(2, 32'h9ABC_DEF0, 1, "sweep32_w1_low");
      check("sweep32_crc", get_out(2), exp_out(e));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
